if_id_queue: RTL and testbench

- Instruction queue and pipeline register between the fetch unit (IFU) and the decode stage.
- Buffers up to DEPTH fetched {pc, instruction} pairs behind a valid/ready handshake on both sides.
- Lets decode stall without losing fetched words, and discards all buffered entries when a taken branch flushes the front end.

---
 rtl/if_id_queue.sv | 151 +++++++++++++++
 tb/tb_if_id_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: instruction queue and pipeline register between fetch and decode.
// Holds up to DEPTH {pc, instruction} pairs in a circular buffer. The head
// entry is presented combinationally to decode. A flush discards every
// buffered entry.
// Optional macro IF_ID_QUEUE_STATS_EN adds three 32-bit statistics counters:
// stall_cycles, full_cycles and flushed_entries.
module if_id_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instruction,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instruction,
    output logic                       out_misaligned,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
`ifdef IF_ID_QUEUE_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                full_cycles,
    output logic [31:0]                flushed_entries
`endif
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [XLEN-1:0]  insn_mem_q [DEPTH];

    logic             not_empty;
    logic             push;
    logic             pop;

    // Handshake qualifiers; in_ready only looks at occupancy, never out_ready
    assign not_empty = reset && (count_q != '0);
    assign in_ready  = reset && (count_q != FULL_CNT);
    assign out_valid = not_empty && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Head entry to decode, NOP bubble when empty or in reset
    always_comb begin
        out_pc          = '0;
        out_instruction = NOP_INSN;
        if (not_empty) begin
            out_pc          = pc_mem_q[head_q];
            out_instruction = insn_mem_q[head_q];
        end
        out_misaligned = out_valid && (out_pc[1:0] != 2'b00);
    end

    // Next pointer and occupancy; flush wins over any same-cycle push
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer/occupancy registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until a push marks them live
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= in_pc;
            insn_mem_q[tail_q] <= in_instruction;
        end
    end

`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] stall_cycles_q,    stall_cycles_d;
    logic [31:0] full_cycles_q,     full_cycles_d;
    logic [31:0] flushed_entries_q, flushed_entries_d;

    // Statistics increments; free-running, wrap at 2^32
    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        full_cycles_d     = full_cycles_q;
        flushed_entries_d = flushed_entries_q;
        if (out_valid && !out_ready) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((count_q == FULL_CNT) && in_valid) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
        if (flush) begin
            flushed_entries_d = flushed_entries_q + 32'(count_q);
        end
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q    <= '0;
            full_cycles_q     <= '0;
            flushed_entries_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            full_cycles_q     <= full_cycles_d;
            flushed_entries_q <= flushed_entries_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign full_cycles     = full_cycles_q;
    assign flushed_entries = flushed_entries_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed, table-driven check of if_id_queue (DEPTH=2).
// Each table row gives the inputs for one cycle and the outputs expected in
// that cycle before its rising edge.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_misaligned;
    logic        out_ready;
    logic [1:0]  count;
`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] full_cycles;
    logic [31:0] flushed_entries;
`endif

    if_id_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_ready        (in_ready),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_misaligned  (out_misaligned),
        .out_ready       (out_ready),
        .count           (count)
`ifdef IF_ID_QUEUE_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .full_cycles     (full_cycles),
        .flushed_entries (flushed_entries)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        f;
        logic        rdy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_mis;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic rst_n, logic v, logic [31:0] pc, logic [31:0] ins,
                                logic f, logic rdy, logic e_ir, logic e_ov,
                                logic [31:0] e_pc, logic [31:0] e_ins, logic e_mis,
                                logic [1:0] e_cnt);
        vec_t r;
        r.rst_n = rst_n; r.v = v; r.pc = pc; r.ins = ins; r.f = f; r.rdy = rdy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_pc = e_pc; r.e_ins = e_ins;
        r.e_mis = e_mis; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic f, input logic rdy);
        reset = rst_n; in_valid = v; in_pc = pc; in_instruction = ins;
        flush = f; out_ready = rdy;
    endtask

    initial begin
        // rst v  pc     ins           f  rdy | ir ov  pc     ins           mis cnt
        vecs[0]  = mk(0, 1, 32'h40, 32'hAAAAAAAA, 1, 1,  0, 0, 32'h00, NOP,          0, 0);
        vecs[1]  = mk(0, 0, 32'h00, 32'h0,        0, 0,  0, 0, 32'h00, NOP,          0, 0);
        vecs[2]  = mk(1, 1, 32'h00, 32'h11111111, 0, 1,  1, 0, 32'h00, NOP,          0, 0);
        vecs[3]  = mk(1, 1, 32'h04, 32'h22222222, 0, 1,  1, 1, 32'h00, 32'h11111111, 0, 1);
        vecs[4]  = mk(1, 1, 32'h08, 32'h33333333, 0, 1,  1, 1, 32'h04, 32'h22222222, 0, 1);
        vecs[5]  = mk(1, 0, 32'h00, 32'h0,        0, 1,  1, 1, 32'h08, 32'h33333333, 0, 1);
        vecs[6]  = mk(1, 0, 32'h00, 32'h0,        0, 0,  1, 0, 32'h00, NOP,          0, 0);
        // decode stall fills the queue, then drains in order
        vecs[7]  = mk(1, 1, 32'h10, 32'hA0A0A0A0, 0, 0,  1, 0, 32'h00, NOP,          0, 0);
        vecs[8]  = mk(1, 1, 32'h14, 32'hA1A1A1A1, 0, 0,  1, 1, 32'h10, 32'hA0A0A0A0, 0, 1);
        vecs[9]  = mk(1, 1, 32'h18, 32'hA2A2A2A2, 0, 0,  0, 1, 32'h10, 32'hA0A0A0A0, 0, 2);
        vecs[10] = mk(1, 1, 32'h18, 32'hA2A2A2A2, 0, 1,  0, 1, 32'h10, 32'hA0A0A0A0, 0, 2);
        vecs[11] = mk(1, 1, 32'h18, 32'hA2A2A2A2, 0, 0,  1, 1, 32'h14, 32'hA1A1A1A1, 0, 1);
        vecs[12] = mk(1, 0, 32'h00, 32'h0,        0, 1,  0, 1, 32'h14, 32'hA1A1A1A1, 0, 2);
        vecs[13] = mk(1, 0, 32'h00, 32'h0,        0, 1,  1, 1, 32'h18, 32'hA2A2A2A2, 0, 1);
        vecs[14] = mk(1, 0, 32'h00, 32'h0,        0, 0,  1, 0, 32'h00, NOP,          0, 0);
        // flush with two entries and an incoming word
        vecs[15] = mk(1, 1, 32'h24, 32'hB0B0B0B0, 0, 0,  1, 0, 32'h00, NOP,          0, 0);
        vecs[16] = mk(1, 1, 32'h28, 32'hB1B1B1B1, 0, 0,  1, 1, 32'h24, 32'hB0B0B0B0, 0, 1);
        vecs[17] = mk(1, 1, 32'h0C, 32'hC0C0C0C0, 1, 1,  0, 0, 32'h24, 32'hB0B0B0B0, 0, 2);
        // flush with one entry while a push would otherwise be accepted
        vecs[18] = mk(1, 1, 32'h20, 32'hD0D0D0D0, 0, 0,  1, 0, 32'h00, NOP,          0, 0);
        vecs[19] = mk(1, 1, 32'h0C, 32'hC0C0C0C0, 1, 1,  1, 0, 32'h20, 32'hD0D0D0D0, 0, 1);
        vecs[20] = mk(1, 1, 32'h20, 32'hD0D0D0D0, 0, 0,  1, 0, 32'h00, NOP,          0, 0);
        vecs[21] = mk(1, 0, 32'h00, 32'h0,        0, 1,  1, 1, 32'h20, 32'hD0D0D0D0, 0, 1);
        // misaligned pc flag
        vecs[22] = mk(1, 1, 32'h06, 32'hE0E0E0E0, 0, 0,  1, 0, 32'h00, NOP,          0, 0);
        vecs[23] = mk(1, 1, 32'h08, 32'hE1E1E1E1, 0, 1,  1, 1, 32'h06, 32'hE0E0E0E0, 1, 1);
        vecs[24] = mk(1, 0, 32'h00, 32'h0,        0, 0,  1, 1, 32'h08, 32'hE1E1E1E1, 0, 1);
        vecs[25] = mk(1, 1, 32'h30, 32'hF0F0F0F0, 0, 0,  1, 1, 32'h08, 32'hE1E1E1E1, 0, 1);
        // reset while full
        vecs[26] = mk(0, 1, 32'h34, 32'hF1F1F1F1, 0, 0,  0, 0, 32'h00, NOP,          0, 2);
        vecs[27] = mk(1, 0, 32'h00, 32'h0,        0, 1,  1, 0, 32'h00, NOP,          0, 0);

        drive(0, 0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].v, vecs[i].pc, vecs[i].ins, vecs[i].f, vecs[i].rdy);
            #1;
            chk($sformatf("row%0d in_ready", i),  32'(in_ready),       32'(vecs[i].e_ir));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid),      32'(vecs[i].e_ov));
            chk($sformatf("row%0d out_pc", i),    out_pc,              vecs[i].e_pc);
            chk($sformatf("row%0d out_insn", i),  out_instruction,     vecs[i].e_ins);
            chk($sformatf("row%0d misalign", i),  32'(out_misaligned), 32'(vecs[i].e_mis));
            chk($sformatf("row%0d count", i),     32'(count),          32'(vecs[i].e_cnt));
`ifdef IF_ID_QUEUE_STATS_EN
            if (i == 26) begin
                chk("stats stall_before_reset",   stall_cycles,    32'd6);
                chk("stats full_before_reset",    full_cycles,     32'd3);
                chk("stats flushed_before_reset", flushed_entries, 32'd3);
            end
            if (i == 27) begin
                chk("stats stall_after_reset",    stall_cycles,    32'd0);
                chk("stats full_after_reset",     full_cycles,     32'd0);
                chk("stats flushed_after_reset",  flushed_entries, 32'd0);
            end
`endif
            $display("row %0d: rst=%0b v=%0b pc=%h f=%0b rdy=%0b -> ir=%0b ov=%0b opc=%h oins=%h mis=%0b cnt=%0d",
                     i, reset, in_valid, in_pc, flush, out_ready,
                     in_ready, out_valid, out_pc, out_instruction, out_misaligned, count);
        end

        // Stalled head stays stable across several cycles
        @(negedge clk);
        drive(1, 1, 32'h100, 32'h00001234, 0, 0);
        #1;
        chk("stall_seq empty_before_push", 32'(count), 32'd0);
        @(negedge clk);
        drive(1, 0, 32'h0, 32'h0, 0, 0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_seq c%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall_seq c%0d out_pc", k),    out_pc,         32'h100);
            chk($sformatf("stall_seq c%0d out_insn", k),  out_instruction, 32'h00001234);
            chk($sformatf("stall_seq c%0d count", k),     32'(count),     32'd1);
            $display("stall cycle %0d: ov=%0b pc=%h ins=%h cnt=%0d", k, out_valid, out_pc, out_instruction, count);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("stall_seq release out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("stall_seq drained count",     32'(count),     32'd0);
        chk("stall_seq drained out_valid", 32'(out_valid), 32'd0);
        chk("stall_seq drained out_insn",  out_instruction, NOP);
        $display("stall release: cnt=%0d ov=%0b ins=%h", count, out_valid, out_instruction);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
